// File: rtl/lb_responder_regbank.sv
// Local-bus register bank: control/scratch registers, free-running counter,
// a capture FIFO with sticky overflow/underflow flags, and a fixed-latency read path.
`timescale 1ns/1ps
module lb_responder_regbank #(
    parameter logic [23:0] BASE_ADDR  = 24'h000000,
    parameter int          READ_DELAY = 3,
    parameter int          FIFO_AW    = 4,
    parameter logic [31:0] ID_WORD    = 32'h6C627231
) (
    input  logic        lb_clk,
    input  logic        reset,
    input  logic        lb_strobe,
    input  logic        lb_rd,
    input  logic        lb_write,
    input  logic [23:0] lb_addr,
    input  logic [31:0] lb_data,
    output logic [31:0] lb_din,
    output logic        lb_din_valid,
    input  logic        cap_valid,
    input  logic [31:0] cap_data,
    input  logic [31:0] status_in,
    output logic [31:0] ctrl0,
    output logic [31:0] ctrl1,
    output logic        ctrl0_wstb
);
    localparam int               DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

    logic [31:0]        r_ctrl0, r_ctrl1, r_scratch, r_cycle;
    logic [1:0]         r_flags;
    logic               r_ctrl0_wstb;
    logic [31:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic [31:0]        r_pipe_data [READ_DELAY];
    logic [READ_DELAY-1:0] r_pipe_vld;

    logic        w_sel, w_rd, w_wr, w_full, w_empty;
    logic        w_pop_req, w_pop, w_push;
    logic [3:0]  w_offset;
    logic [1:0]  w_flag_set, w_flag_clr;
    logic [31:0] w_fifo_status, w_rd_mux;

    assign w_sel    = (lb_addr[23:4] == BASE_ADDR[23:4]);
    assign w_offset = lb_addr[3:0];
    // A strobe with both rd and write set is a read; the write is suppressed.
    assign w_rd     = w_sel && lb_strobe && lb_rd;
    assign w_wr     = w_sel && lb_strobe && lb_write && !lb_rd;

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_pop_req = w_rd && (w_offset == 4'h6);
    assign w_pop     = w_pop_req && !w_empty;
    assign w_push    = cap_valid && (!w_full || w_pop);

    assign w_flag_set = {w_pop_req && w_empty, cap_valid && w_full && !w_pop};
    assign w_flag_clr = (w_wr && w_offset == 4'h8) ? lb_data[1:0] : 2'b00;

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        w_fifo_status            = '0;
        w_fifo_status[31]        = w_full;
        w_fifo_status[30]        = w_empty;
        w_fifo_status[FIFO_AW:0] = r_count;
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_offset)
            4'h0:    w_rd_mux = r_ctrl0;
            4'h1:    w_rd_mux = r_ctrl1;
            4'h2:    w_rd_mux = r_scratch;
            4'h3:    w_rd_mux = ID_WORD;
            4'h4:    w_rd_mux = r_cycle;
            4'h5:    w_rd_mux = status_in;
            4'h6:    w_rd_mux = w_empty ? 32'h0 : r_mem[r_rd_ptr];
            4'h7:    w_rd_mux = w_fifo_status;
            4'h8:    w_rd_mux = {30'h0, r_flags};
            default: w_rd_mux = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge lb_clk) begin
        if (reset) begin
            r_ctrl0      <= '0;
            r_ctrl1      <= '0;
            r_scratch    <= '0;
            r_cycle      <= '0;
            r_flags      <= '0;
            r_ctrl0_wstb <= 1'b0;
        end else begin
            r_cycle      <= r_cycle + 32'd1;
            r_ctrl0_wstb <= w_wr && (w_offset == 4'h0);
            if (w_wr) begin
                case (w_offset)
                    4'h0:    r_ctrl0   <= lb_data;
                    4'h1:    r_ctrl1   <= lb_data;
                    4'h2:    r_scratch <= lb_data;
                    default: ;
                endcase
            end
            // Set has priority over a same-cycle write-1-to-clear.
            r_flags <= (r_flags & ~w_flag_clr) | w_flag_set;
        end
    end

    always_ff @(posedge lb_clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: ;
            endcase
        end
    end

    // NOTE: FIFO storage is deliberately not reset; emptiness is tracked by
    // the pointers and count, so stale contents are never observable.
    always_ff @(posedge lb_clk) begin
        if (!reset && w_push) r_mem[r_wr_ptr] <= cap_data;
    end

    // Read pipeline: stage 0 captures the source in the strobe cycle; data
    // stages only load behind a valid so the last stage holds between reads.
    always_ff @(posedge lb_clk) begin
        if (reset) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < READ_DELAY; i++) r_pipe_data[i] <= '0;
        end else begin
            r_pipe_vld[0] <= w_rd;
            if (w_rd) r_pipe_data[0] <= w_rd_mux;
            for (int i = 1; i < READ_DELAY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                if (r_pipe_vld[i-1]) r_pipe_data[i] <= r_pipe_data[i-1];
            end
        end
    end

    assign lb_din       = r_pipe_data[READ_DELAY-1];
    assign lb_din_valid = r_pipe_vld[READ_DELAY-1];
    assign ctrl0        = r_ctrl0;
    assign ctrl1        = r_ctrl1;
    assign ctrl0_wstb   = r_ctrl0_wstb;

endmodule

// File: tb/tb_lb_responder_regbank.sv
// Scoreboard bench for lb_responder_regbank: reads push expected data and
// due cycle into queues; a negedge monitor pops and compares on lb_din_valid.
`timescale 1ns/1ps
module tb_lb_responder_regbank;
    localparam logic [23:0] BASE    = 24'h000000;
    localparam int          RD_DLY  = 3;
    localparam logic [31:0] ID      = 32'h6C627231;

    logic        lb_clk, reset, lb_strobe, lb_rd, lb_write;
    logic [23:0] lb_addr;
    logic [31:0] lb_data, lb_din, cap_data, status_in, ctrl0, ctrl1;
    logic        lb_din_valid, cap_valid, ctrl0_wstb;

    int n_total = 0;
    int n_pass  = 0;
    int stray   = 0;
    int cyc     = 0;
    logic [31:0] exp_q [$];
    int          due_q [$];

    lb_responder_regbank #(
        .BASE_ADDR(BASE), .READ_DELAY(RD_DLY), .FIFO_AW(4), .ID_WORD(ID)
    ) dut (
        .lb_clk(lb_clk), .reset(reset), .lb_strobe(lb_strobe), .lb_rd(lb_rd),
        .lb_write(lb_write), .lb_addr(lb_addr), .lb_data(lb_data),
        .lb_din(lb_din), .lb_din_valid(lb_din_valid), .cap_valid(cap_valid),
        .cap_data(cap_data), .status_in(status_in), .ctrl0(ctrl0),
        .ctrl1(ctrl1), .ctrl0_wstb(ctrl0_wstb)
    );

    initial lb_clk = 1'b0;
    always #5 lb_clk = ~lb_clk;
    always @(posedge lb_clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every valid must match the oldest expectation at its due cycle.
    always @(negedge lb_clk) begin
        if (lb_din_valid) begin
            if (exp_q.size() == 0) begin
                stray++;
                n_total++;
                $display("FAIL unexpected_valid: got lb_din 0x%08h with no read pending (cycle %0d)", lb_din, cyc);
            end else begin
                logic [31:0] e;
                int          d;
                e = exp_q.pop_front();
                d = due_q.pop_front();
                check("rd_data", lb_din, e);
                check("rd_latency", 32'(cyc), 32'(d));
            end
        end
    end

    task automatic tick();
        @(posedge lb_clk);
        #1;
    endtask

    task automatic rd(input logic [23:0] a, input logic [31:0] exp, input bit want);
        lb_strobe = 1'b1; lb_rd = 1'b1; lb_write = 1'b0; lb_addr = a;
        if (want) begin
            exp_q.push_back(exp);
            due_q.push_back(cyc + RD_DLY);
        end
        tick();
        lb_strobe = 1'b0; lb_rd = 1'b0;
    endtask

    task automatic wr(input logic [23:0] a, input logic [31:0] d);
        lb_strobe = 1'b1; lb_rd = 1'b0; lb_write = 1'b1; lb_addr = a; lb_data = d;
        tick();
        lb_strobe = 1'b0; lb_write = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        cap_valid = 1'b1; cap_data = d;
        tick();
        cap_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; lb_strobe = 1'b0; lb_rd = 1'b0; lb_write = 1'b0;
        lb_addr = '0; lb_data = '0; cap_valid = 1'b0; cap_data = '0;
        status_in = 32'h5A5A1234;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state, and counter starts at 0 in the first cycle out of reset
        check("rst_ctrl0", ctrl0, 32'h0);
        check("rst_ctrl1", ctrl1, 32'h0);
        check("rst_wstb", {31'h0, ctrl0_wstb}, 32'h0);
        check("rst_valid", {31'h0, lb_din_valid}, 32'h0);
        check("rst_din", lb_din, 32'h0);
        rd(BASE + 24'h4, 32'h0, 1'b1);
        rd(BASE + 24'h4, 32'h1, 1'b1);
        rd(BASE + 24'h7, 32'h4000_0000, 1'b1);
        rd(BASE + 24'h8, 32'h0, 1'b1);

        // ctrl0 write: visible next cycle with a single strobe pulse
        wr(BASE + 24'h0, 32'h1234_5678);
        check("ctrl0_wr", ctrl0, 32'h1234_5678);
        check("wstb_hi", {31'h0, ctrl0_wstb}, 32'h1);
        tick();
        check("wstb_lo", {31'h0, ctrl0_wstb}, 32'h0);
        rd(BASE + 24'h0, 32'h1234_5678, 1'b1);

        wr(BASE + 24'h1, 32'hA5A5_0001);
        check("ctrl1_wr", ctrl1, 32'hA5A5_0001);
        check("ctrl1_nostb", {31'h0, ctrl0_wstb}, 32'h0);
        wr(BASE + 24'h2, 32'hCAFE_F00D);
        // rd+write together is a read; scratch keeps its value
        lb_strobe = 1'b1; lb_rd = 1'b1; lb_write = 1'b1;
        lb_addr = BASE + 24'h2; lb_data = 32'hDEAD_BEEF;
        exp_q.push_back(32'hCAFE_F00D); due_q.push_back(cyc + RD_DLY);
        tick();
        lb_strobe = 1'b0; lb_rd = 1'b0; lb_write = 1'b0;

        // Back-to-back reads, unmapped offset, status, then an out-of-block read
        rd(BASE + 24'h3, ID, 1'b1);
        rd(BASE + 24'h2, 32'hCAFE_F00D, 1'b1);
        rd(BASE + 24'h9, 32'h0, 1'b1);
        rd(BASE + 24'h5, 32'h5A5A_1234, 1'b1);
        rd(24'h000013, 32'h0, 1'b0);
        wr(24'h000010, 32'hFFFF_FFFF);
        check("oob_wr_ctrl0", ctrl0, 32'h1234_5678);
        check("oob_wr_wstb", {31'h0, ctrl0_wstb}, 32'h0);
        repeat (RD_DLY + 2) tick();
        check("din_hold", lb_din, 32'h5A5A_1234);
        check("valid_idle", {31'h0, lb_din_valid}, 32'h0);

        // Overfill: 17 pushes, overflow sticky, 16 pops in order, then underflow
        for (int i = 1; i <= 17; i++) push(32'(i));
        rd(BASE + 24'h7, 32'h8000_0010, 1'b1);
        rd(BASE + 24'h8, 32'h1, 1'b1);
        for (int i = 1; i <= 16; i++) rd(BASE + 24'h6, 32'(i), 1'b1);
        rd(BASE + 24'h6, 32'h0, 1'b1);
        rd(BASE + 24'h8, 32'h3, 1'b1);
        rd(BASE + 24'h7, 32'h4000_0000, 1'b1);
        wr(BASE + 24'h8, 32'h3);
        rd(BASE + 24'h8, 32'h0, 1'b1);

        // Full FIFO: push and pop together keeps count, no overflow, 0xAA last
        for (int i = 0; i < 16; i++) push(32'h100 + 32'(i));
        cap_valid = 1'b1; cap_data = 32'hAA;
        rd(BASE + 24'h6, 32'h100, 1'b1);
        cap_valid = 1'b0;
        rd(BASE + 24'h7, 32'h8000_0010, 1'b1);
        rd(BASE + 24'h8, 32'h0, 1'b1);
        for (int i = 1; i < 16; i++) rd(BASE + 24'h6, 32'h100 + 32'(i), 1'b1);
        rd(BASE + 24'h6, 32'hAA, 1'b1);
        rd(BASE + 24'h7, 32'h4000_0000, 1'b1);

        // Empty FIFO: push and pop together -> read 0, underflow, count 1
        cap_valid = 1'b1; cap_data = 32'h77;
        rd(BASE + 24'h6, 32'h0, 1'b1);
        cap_valid = 1'b0;
        rd(BASE + 24'h7, 32'h0000_0001, 1'b1);
        rd(BASE + 24'h8, 32'h2, 1'b1);

        // Clear both flags while overflow sets in the same cycle: set wins
        for (int i = 1; i < 16; i++) push(32'h200 + 32'(i));
        cap_valid = 1'b1; cap_data = 32'hBB;
        wr(BASE + 24'h8, 32'h3);
        cap_valid = 1'b0;
        rd(BASE + 24'h8, 32'h1, 1'b1);
        rd(BASE + 24'h7, 32'h8000_0010, 1'b1);
        rd(BASE + 24'h6, 32'h77, 1'b1);
        for (int i = 1; i < 16; i++) rd(BASE + 24'h6, 32'h200 + 32'(i), 1'b1);
        rd(BASE + 24'h7, 32'h4000_0000, 1'b1);
        repeat (RD_DLY + 2) tick();

        // Reset one cycle after a read strobe: the read is discarded;
        // a write strobed while reset is high is dropped
        rd(BASE + 24'h4, 32'h0, 1'b0);
        reset = 1'b1;
        wr(BASE + 24'h1, 32'h0000_0099);
        tick();
        reset = 1'b0;
        check("rstwr_ctrl1", ctrl1, 32'h0);
        check("rst2_ctrl0", ctrl0, 32'h0);
        rd(BASE + 24'h4, 32'h0, 1'b1);
        rd(BASE + 24'h8, 32'h0, 1'b1);
        rd(BASE + 24'h7, 32'h4000_0000, 1'b1);
        repeat (RD_DLY + 3) tick();
        check("no_stray_valid", 32'(stray), 32'h0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d reads still pending, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
